// File: rtl/single.sv
// Control decoder for the LEGv8 unconditional branch B.
// The instruction is decoded into named control fields every cycle, and the
// packed control word is registered once per clock.
module single (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i,
  output logic [93:0] CW
);

  localparam logic [5:0] B_OP = 6'b000101;

  logic [5:0]  w_opcode;
  logic [25:0] w_imm26;

  // Decoded control fields for the current instruction word.
  logic [4:0]  DA;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [4:0]  FS;
  logic [1:0]  PS;
  logic [1:0]  enable;
  logic        regWrite;
  logic        memWrite;
  logic        PC_sel;
  logic        B_sel;
  logic        status_load;
  logic [63:0] k;
  logic        state;

  logic [93:0] r_cw;

  assign w_opcode = i[31:26];
  assign w_imm26  = i[25:0];

  // Decode: every field defaults to zero, so a non-B opcode yields CW = 0.
  always_comb begin
    DA          = 5'd0;
    SA          = 5'd0;
    SB          = 5'd0;
    FS          = 5'd0;
    PS          = 2'b00;
    enable      = 2'b00;
    regWrite    = 1'b0;
    memWrite    = 1'b0;
    PC_sel      = 1'b0;
    B_sel       = 1'b0;
    status_load = 1'b0;
    k           = 64'd0;
    state       = 1'b0;
    if (w_opcode == B_OP) begin
      // Word offset is sign-extended but not scaled; the PC unit applies x4.
      k      = {{38{w_imm26[25]}}, w_imm26};
      PS     = 2'b11;
      PC_sel = 1'b1;
    end
  end

  // Register the packed control word; reset clears it with priority over decode.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cw <= 94'd0;
    end else begin
      r_cw <= {k, DA, SA, SB, FS, PS, enable, regWrite, memWrite,
               PC_sel, B_sel, status_load, state};
    end
  end

  assign CW = r_cw;

endmodule

// File: tb/tb_single.sv
// Self-checking bench for the B-instruction control decoder.
module tb_single;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] i;
  logic [93:0] CW;

  always #5 clock = ~clock;

  single dut (
    .clock (clock),
    .reset (reset),
    .i     (i),
    .CW    (CW)
  );

  int total = 0;
  int bad   = 0;

  logic [93:0] sb_q[$];
  string       nm_q[$];

  typedef struct {
    logic [31:0] iv;
    logic        rv;
    logic [63:0] k;
    logic [1:0]  ps;
    logic        pcs;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  // Expected CW built from the three fields a B can set; everything else is 0.
  function automatic logic [93:0] pack(input logic [63:0] kk, input logic [1:0] ps,
                                       input logic pcs);
    return {kk, 20'd0, ps, 2'b00, 1'b0, 1'b0, pcs, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic vec_t mk(input logic [31:0] iv, input logic rv, input logic [63:0] kk,
                              input logic [1:0] ps, input logic pcs, input string nm);
    vec_t v;
    v.iv = iv; v.rv = rv; v.k = kk; v.ps = ps; v.pcs = pcs; v.nm = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [93:0] act, input logic [93:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, and compare after the edge.
  task automatic apply(input logic [31:0] iv, input logic rv, input logic [93:0] exp,
                       input string nm);
    logic [93:0] e;
    string       n;
    i     = iv;
    reset = rv;
    sb_q.push_back(exp);
    nm_q.push_back(nm);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      check(n, CW, e);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [93:0] held;
    logic [31:0] rv_i;
    logic [63:0] kv;

    reset = 1'b0;
    i     = 32'h14000004;

    tbl.push_back(mk(32'h14000004, 1'b0, 64'd0, 2'b00, 1'b0, "reset_edge1"));
    tbl.push_back(mk(32'h14000004, 1'b0, 64'd0, 2'b00, 1'b0, "reset_edge2"));
    tbl.push_back(mk(32'h14000004, 1'b1, 64'd4, 2'b11, 1'b1, "reset_release"));
    tbl.push_back(mk(32'b000101_00000000000000000000000100, 1'b1,
                     64'h0000000000000004, 2'b11, 1'b1, "pos_offset"));
    tbl.push_back(mk(32'b000101_10000000000000000000000100, 1'b1,
                     64'hFFFFFFFFFE000004, 2'b11, 1'b1, "neg_offset"));
    tbl.push_back(mk(32'h17FFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 2'b11, 1'b1, "ext_all_ones"));
    tbl.push_back(mk(32'h15FFFFFF, 1'b1, 64'h0000000001FFFFFF, 2'b11, 1'b1, "ext_max_pos"));
    tbl.push_back(mk(32'h00000000, 1'b1, 64'd0, 2'b00, 1'b0, "zero_instr"));
    tbl.push_back(mk(32'h94000004, 1'b1, 64'd0, 2'b00, 1'b0, "bl_opcode"));
    tbl.push_back(mk(32'h14000000, 1'b1, 64'd0, 2'b11, 1'b1, "b_zero_offset"));
    tbl.push_back(mk(32'h1C000004, 1'b1, 64'd0, 2'b00, 1'b0, "near_miss_000111"));
    tbl.push_back(mk(32'h10000004, 1'b1, 64'd0, 2'b00, 1'b0, "near_miss_000100"));
    tbl.push_back(mk(32'h16000000, 1'b1, 64'hFFFFFFFFFE000000, 2'b11, 1'b1, "most_negative"));

    @(negedge clock);
    for (int n = 0; n < tbl.size(); n++) begin
      apply(tbl[n].iv, tbl[n].rv, pack(tbl[n].k, tbl[n].ps, tbl[n].pcs), tbl[n].nm);
    end

    // Back-to-back alternating B instructions with a one-edge reset in the middle.
    for (int n = 0; n < 8; n++) begin
      if (n == 4) begin
        apply(32'b000101_10000000000000000000000100, 1'b0, 94'd0, "midstream_reset");
      end else if (n % 2 == 0) begin
        apply(32'b000101_00000000000000000000000100, 1'b1,
              pack(64'h4, 2'b11, 1'b1), "b2b_pos");
      end else begin
        apply(32'b000101_10000000000000000000000100, 1'b1,
              pack(64'hFFFFFFFFFE000004, 2'b11, 1'b1), "b2b_neg");
      end
    end

    // Reset has no asynchronous effect: CW holds until the next edge.
    apply(32'h15FFFFFF, 1'b1, pack(64'h0000000001FFFFFF, 2'b11, 1'b1), "preload");
    held  = CW;
    reset = 1'b0;
    #2;
    check("reset_not_async", CW, pack(64'h0000000001FFFFFF, 2'b11, 1'b1));
    apply(32'h15FFFFFF, 1'b0, 94'd0, "reset_on_edge");
    apply(32'h17FFFFFF, 1'b1, pack(64'hFFFFFFFFFFFFFFFF, 2'b11, 1'b1), "resume_after_reset");
    if (held == 94'd0) begin
      total++;
      bad++;
      $display("FAIL preload_nonzero: got %h expected nonzero", held);
    end

    // Combinational internal fields track the current instruction word.
    i = 32'h16000004;
    #1;
    check("int_k", {30'd0, dut.k}, {30'd0, 64'hFFFFFFFFFE000004});
    check("int_PS_PCsel", {91'd0, dut.PS, dut.PC_sel}, {91'd0, 2'b11, 1'b1});
    @(negedge clock);

    // Randomised instructions against an arithmetic sign-extension model.
    for (int n = 0; n < 24; n++) begin
      rv_i = $urandom;
      if ($urandom_range(0, 1) == 1) rv_i[31:26] = 6'b000101;
      if (rv_i[31:26] == 6'b000101) begin
        kv = 64'(rv_i[25:0]);
        if (rv_i[25]) kv = kv - (64'd1 << 26);
        apply(rv_i, 1'b1, pack(kv, 2'b11, 1'b1), "random_b");
      end else begin
        apply(rv_i, 1'b1, 94'd0, "random_other");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
